pipe_buffer_ctrl: RTL and testbench

Sequencing controller for the 2-bit survivor pipeline buffer in the Viterbi decoder. The buffer is a free-running, enable-less delay line with a synchronous reset; it cannot tell real symbols from idle slots. This block clears the buffer, admits symbols, and tracks which slots hold valid data, producing a valid strobe aligned with the buffer output. It also supports controlled drain (flush) and abort. It sits beside the buffer in the decoder datapath and drives the buffer's reset input.

---
 rtl/viterbi_pipe_pkg.sv | 15 +
 rtl/pipe_valid_tracker.sv | 38 +++
 rtl/pipe_buffer_ctrl.sv | 81 ++++++++
 tb/tb_pipe_buffer_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pipe_pkg.sv
// Shared types and constants for the Viterbi survivor pipeline buffer control.
// State encoding, default depth and symbol width.
package viterbi_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } pipe_state_t;

    localparam int DEPTH_DEF = 32;
    localparam int SYM_W     = 2;

endpackage

// File: rtl/pipe_valid_tracker.sv
// Valid-bit shadow of the survivor buffer plus its occupancy count.
// vsr mirrors the buffer stage by stage; occupancy is popcount(vsr).
module pipe_valid_tracker
    import viterbi_pipe_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             shift_in,
    output logic             out_valid,
    output logic [CNT_W-1:0] occupancy
);

    logic [DEPTH-1:0] vsr;

    assign out_valid = vsr[DEPTH-1];

    // Shift valid bits alongside the buffer and keep a running count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsr       <= '0;
            occupancy <= '0;
        end else if (clr) begin
            vsr       <= '0;
            occupancy <= '0;
        end else begin
            vsr <= {vsr[DEPTH-2:0], shift_in};
            if (shift_in && !out_valid)
                occupancy <= occupancy + CNT_W'(1);
            else if (!shift_in && out_valid)
                occupancy <= occupancy - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_buffer_ctrl.sv
// Session controller for the survivor buffer: clear, admit, drain, abort.
// Drives the buffer reset and a valid strobe aligned with its output.
module pipe_buffer_ctrl
    import viterbi_pipe_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             buf_clear,
    output logic             out_valid,
    output logic [CNT_W-1:0] occupancy,
    output logic             busy,
    output logic             flush_done,
    output logic             drop_err,
    output logic [1:0]       state
);

    pipe_state_t cur, nxt;
    logic        accepted;

    assign in_ready   = (cur == RUN);
    assign buf_clear  = (cur == CLEAR);
    assign busy       = (cur != IDLE);
    assign flush_done = (cur == DRAIN) && (occupancy == '0);
    assign accepted   = in_valid & in_ready;
    assign state      = cur;

    pipe_valid_tracker #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_trk (
        .clock     (clock),
        .reset     (reset),
        .clr       (buf_clear),
        .shift_in  (accepted),
        .out_valid (out_valid),
        .occupancy (occupancy)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            cur <= IDLE;
        else
            cur <= nxt;
    end

    // Next-state decode; an abort overrides every other request.
    always_comb begin
        nxt = cur;
        if (clear) begin
            nxt = CLEAR;
        end else begin
            unique case (cur)
                IDLE:  if (start) nxt = CLEAR;
                CLEAR: nxt = RUN;
                RUN:   if (flush) nxt = DRAIN;
                DRAIN: if (occupancy == '0) nxt = IDLE;
                default: nxt = IDLE;
            endcase
        end
    end

    // Sticky flag for symbols offered while admission was closed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            drop_err <= 1'b0;
        else if (cur == CLEAR)
            drop_err <= 1'b0;
        else if (in_valid && !in_ready)
            drop_err <= 1'b1;
    end

endmodule

// File: tb/tb_pipe_buffer_ctrl.sv
// Directed testbench for pipe_buffer_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_pipe_buffer_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, clear, flush, in_valid;
    logic       in_ready, buf_clear, out_valid, busy;
    logic       flush_done, drop_err;
    logic [5:0] occupancy;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;
    int ones, first, lastv, dones, done_at, bad, e;

    pipe_buffer_ctrl #(.DEPTH(32), .CNT_W(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .clear      (clear),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .buf_clear  (buf_clear),
        .out_valid  (out_valid),
        .occupancy  (occupancy),
        .busy       (busy),
        .flush_done (flush_done),
        .drop_err   (drop_err),
        .state      (state)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_buf_clear"}, int'(buf_clear), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_occ"}, int'(occupancy), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_flush_done"}, int'(flush_done), 0);
        chk({tag, "_drop_err"}, int'(drop_err), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clear = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        chk_all_zero("rst");
        reset = 1'b0;
        step();

        // in_valid in IDLE raises a sticky drop_err; CLEAR wipes it
        in_valid = 1'b1;
        step();
        chk("drop_set", int'(drop_err), 1);
        in_valid = 1'b0;
        step();
        chk("drop_hold", int'(drop_err), 1);
        start = 1'b1;
        step();
        chk("clr_state", int'(state), 1);
        chk("clr_bufclr", int'(buf_clear), 1);
        chk("clr_ready", int'(in_ready), 0);
        chk("clr_drop", int'(drop_err), 1);
        start = 1'b0;
        step();
        chk("run_state", int'(state), 2);
        chk("run_ready", int'(in_ready), 1);
        chk("run_bufclr", int'(buf_clear), 0);
        chk("drop_clr", int'(drop_err), 0);

        // five accepts -> five out_valid cycles, first at edge offset 31
        ones = 0;
        first = -1;
        in_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            if (i == 5) in_valid = 1'b0;
            step();
            if (out_valid) begin
                ones++;
                if (first < 0) first = i;
            end
            if (i == 4) chk("five_occ", int'(occupancy), 5);
        end
        chk("five_first", first, 31);
        chk("five_count", ones, 5);
        chk("five_occ_end", int'(occupancy), 0);
        chk("start_ignored", int'(state), 2);

        // continuous stream saturates at DEPTH
        bad = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) start = 1'b1;
            step();
            start = 1'b0;
            if (i < 31 && (out_valid || int'(occupancy) != i + 1)) bad++;
            if (i >= 31 && (!out_valid || occupancy != 6'd32)) bad++;
            if (i == 31) begin
                chk("sat_occ", int'(occupancy), 32);
                chk("sat_ov", int'(out_valid), 1);
            end
        end
        chk("sat_bad", bad, 0);

        // drain partway, then abort with 7 symbols inside
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("drn_state", int'(state), 3);
        chk("drn_ready", int'(in_ready), 0);
        chk("drn_occ", int'(occupancy), 31);
        e = 0;
        while (occupancy != 6'd7 && e < 40) begin
            step();
            e++;
        end
        chk("drn_occ7", int'(occupancy), 7);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("abort_state", int'(state), 1);
        chk("abort_bufclr", int'(buf_clear), 1);
        chk("abort_fd", int'(flush_done), 0);
        step();
        chk("abort_run", int'(state), 2);
        chk("abort_occ", int'(occupancy), 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid || flush_done) bad++;
        end
        chk("abort_quiet", bad, 0);

        // flush on an empty buffer completes in the first DRAIN cycle
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("empty_drn", int'(state), 3);
        chk("empty_fd", int'(flush_done), 1);
        step();
        chk("empty_idle", int'(state), 0);
        chk("empty_fd0", int'(flush_done), 0);
        chk("empty_busy", int'(busy), 0);

        // three symbols, flush together with the third
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        in_valid = 1'b1;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("f3_state", int'(state), 3);
        chk("f3_ready", int'(in_ready), 0);
        chk("f3_occ", int'(occupancy), 3);
        ones = 0;
        dones = 0;
        lastv = -100;
        done_at = -100;
        for (int i = 0; i < 45; i++) begin
            step();
            if (out_valid) begin
                ones++;
                lastv = i;
            end
            if (flush_done) begin
                dones++;
                done_at = i;
            end
        end
        chk("f3_ov_count", ones, 3);
        chk("f3_last_ov", lastv, 30);
        chk("f3_fd_count", dones, 1);
        chk("f3_fd_at", done_at, 31);
        chk("f3_idle", int'(state), 0);

        // start+clear in IDLE, fill to 10, then async reset mid-cycle
        start = 1'b1;
        clear = 1'b1;
        step();
        start = 1'b0;
        clear = 1'b0;
        chk("sc_state", int'(state), 1);
        step();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        in_valid = 1'b0;
        chk("pre_rst_occ", int'(occupancy), 10);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async");
        #2;
        reset = 1'b0;
        step();
        chk("post_rst_idle", int'(state), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("re_bufclr", int'(buf_clear), 1);
        chk("re_ready0", int'(in_ready), 0);
        step();
        chk("re_bufclr0", int'(buf_clear), 0);
        chk("re_ready", int'(in_ready), 1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (out_valid) bad++;
        end
        chk("re_no_stale", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
